// File: rtl/clk_step_ctrl.sv
// clk_step_ctrl: sequencing controller for the processor's divided clock.
// Issues single-cycle ClkEn ticks in halted, free-run, single-step and
// counted-burst modes. A processor halt request overrides everything, and
// a 32-bit counter tracks every tick issued.
module clk_step_ctrl #(
   parameter int unsigned DIV0 = 1,
   parameter int unsigned DIV1 = 1000,
   parameter int unsigned DIV2 = 100000,
   parameter int unsigned DIV3 = 50000000
) (
   input  logic        Clk,
   input  logic        Rst,
   input  logic [1:0]  Mode,
   input  logic [1:0]  DivSel,
   input  logic        StepBtn,
   input  logic [7:0]  BurstLen,
   input  logic        HaltReq,
   input  logic        ClrCnt,
   output logic        ClkEn,
   output logic        Busy,
   output logic        Halted,
   output logic [7:0]  Remain,
   output logic [31:0] CycleCnt,
   output logic [1:0]  StateDbg
);

   localparam logic [1:0] MODE_STOP  = 2'b00;
   localparam logic [1:0] MODE_RUN   = 2'b01;
   localparam logic [1:0] MODE_STEP  = 2'b10;
   localparam logic [1:0] MODE_BURST = 2'b11;

   // Terminal values are period-1: a period of N cycles counts 0..N-1.
   localparam logic [25:0] TERM0 = 26'(DIV0 - 1);
   localparam logic [25:0] TERM1 = 26'(DIV1 - 1);
   localparam logic [25:0] TERM2 = 26'(DIV2 - 1);
   localparam logic [25:0] TERM3 = 26'(DIV3 - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      BURST = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state;
   state_t      nextState;
   logic        btnSync1;
   logic        btnSync2;
   logic        btnPrev;
   logic        rise;
   logic [25:0] divCnt;
   logic [25:0] divCntNext;
   logic [25:0] divTerm;
   logic        divActive;
   logic        termEv;
   logic        haltEntry;
   logic        tickNext;
   logic [7:0]  remainNext;

   // Two-flop synchronizer on the button plus a history flop for edge detect.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         btnSync1 <= 1'b0;
         btnSync2 <= 1'b0;
         btnPrev  <= 1'b0;
      end else begin
         btnSync1 <= StepBtn;
         btnSync2 <= btnSync1;
         btnPrev  <= btnSync2;
      end
   end

   // A held button produces exactly one rise.
   assign rise = btnSync2 & ~btnPrev;

   // Select the divider terminal count.
   always_comb begin
      divTerm = TERM0;
      case (DivSel)
         2'd0:    divTerm = TERM0;
         2'd1:    divTerm = TERM1;
         2'd2:    divTerm = TERM2;
         default: divTerm = TERM3;
      endcase
   end

   // The >= compare lets a switch to a shorter period wrap at once instead
   // of running the counter all the way around.
   assign divActive = (state == RUN) || (state == BURST);
   assign termEv    = divActive && (divCnt >= divTerm);
   assign haltEntry = HaltReq && (state != HALT);

   // State register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) state <= IDLE;
      else     state <= nextState;
   end

   // Next-state decode; a halt request beats every other transition.
   always_comb begin
      nextState = state;
      if (haltEntry) begin
         nextState = HALT;
      end else begin
         case (state)
            IDLE: begin
               if (Mode == MODE_RUN)
                  nextState = RUN;
               else if (Mode == MODE_BURST && rise && BurstLen != 8'd0)
                  nextState = BURST;
            end
            RUN: begin
               if (Mode != MODE_RUN) nextState = IDLE;
            end
            BURST: begin
               if (Mode == MODE_STOP)
                  nextState = IDLE;
               else if (termEv && Remain == 8'd1)
                  nextState = IDLE;
            end
            HALT: begin
               if (Mode == MODE_STOP && !HaltReq) nextState = IDLE;
            end
            default: nextState = IDLE;
         endcase
      end
   end

   // Output decode: tick, burst remainder and divider next values.
   always_comb begin
      tickNext   = 1'b0;
      remainNext = Remain;
      divCntNext = '0;
      if (haltEntry) begin
         remainNext = '0;
      end else begin
         case (state)
            IDLE: begin
               if (Mode == MODE_STEP && rise) tickNext = 1'b1;
               if (Mode == MODE_BURST && rise && BurstLen != 8'd0) remainNext = BurstLen;
            end
            RUN: begin
               if (Mode == MODE_RUN && termEv) tickNext = 1'b1;
            end
            BURST: begin
               if (Mode == MODE_STOP) begin
                  remainNext = '0;
               end else if (termEv) begin
                  tickNext   = 1'b1;
                  remainNext = Remain - 8'd1;
               end
            end
            default: ;
         endcase
      end
      // Divider only runs while staying in RUN/BURST; entry and exit zero it.
      if (divActive && nextState == state) divCntNext = termEv ? '0 : divCnt + 26'd1;
   end

   // Registered outputs and divider; Busy/Halted follow the state edge.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         ClkEn  <= 1'b0;
         Busy   <= 1'b0;
         Halted <= 1'b0;
         Remain <= '0;
         divCnt <= '0;
      end else begin
         ClkEn  <= tickNext;
         Busy   <= (nextState == RUN) || (nextState == BURST);
         Halted <= (nextState == HALT);
         Remain <= remainNext;
         divCnt <= divCntNext;
      end
   end

   // Tick counter; a clear request wins over a simultaneous tick.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst)           CycleCnt <= '0;
      else if (ClrCnt)   CycleCnt <= '0;
      else if (tickNext) CycleCnt <= CycleCnt + 32'd1;
   end

   assign StateDbg = state;

endmodule

// File: tb/tb_clk_step_ctrl.sv
// Testbench for clk_step_ctrl: directed run/step/burst/halt sequences, a
// per-cycle vector table, and randomized stimulus against a reference model.
module tb_clk_step_ctrl;

   logic        Clk = 1'b0;
   logic        Rst;
   logic [1:0]  Mode;
   logic [1:0]  DivSel;
   logic        StepBtn;
   logic [7:0]  BurstLen;
   logic        HaltReq;
   logic        ClrCnt;
   logic        ClkEn;
   logic        Busy;
   logic        Halted;
   logic [7:0]  Remain;
   logic [31:0] CycleCnt;
   logic [1:0]  StateDbg;

   int nCmp = 0;
   int nErr = 0;

   clk_step_ctrl dut (
      .Clk(Clk), .Rst(Rst), .Mode(Mode), .DivSel(DivSel), .StepBtn(StepBtn),
      .BurstLen(BurstLen), .HaltReq(HaltReq), .ClrCnt(ClrCnt), .ClkEn(ClkEn),
      .Busy(Busy), .Halted(Halted), .Remain(Remain), .CycleCnt(CycleCnt),
      .StateDbg(StateDbg)
   );

   // ---------------- clock / watchdog ----------------
   always #5 Clk = ~Clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- check helpers ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nCmp++;
      if (act !== exp) begin
         nErr++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic ck, input logic bsy,
                          input logic hlt, input logic [7:0] rem, input logic [31:0] cnt);
      chk({name, ".ClkEn"},    ClkEn,    ck);
      chk({name, ".Busy"},     Busy,     bsy);
      chk({name, ".Halted"},   Halted,   hlt);
      chk({name, ".Remain"},   Remain,   rem);
      chk({name, ".CycleCnt"}, CycleCnt, cnt);
   endtask

   // ---------------- driver tasks ----------------
   task automatic next_edge();
      @(posedge Clk);
      #1;
   endtask

   task automatic apply_reset();
      Rst = 1'b1; Mode = 2'd0; DivSel = 2'd0; StepBtn = 1'b0;
      BurstLen = 8'd0; HaltReq = 1'b0; ClrCnt = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      Rst = 1'b0;
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic [1:0]  mode;
      logic        btn;
      logic [7:0]  blen;
      logic        halt;
      logic        clr;
      logic        ck;
      logic        busy;
      logic        hlt;
      logic [7:0]  rem;
      logic [31:0] cnt;
   } vec_t;

   vec_t vecs[19];

   task automatic put(input int i, input logic [1:0] m, input logic b, input logic [7:0] bl,
                      input logic h, input logic c, input logic eck, input logic ebsy,
                      input logic ehlt, input logic [7:0] erem, input logic [31:0] ecnt);
      vecs[i] = '{m, b, bl, h, c, eck, ebsy, ehlt, erem, ecnt};
   endtask

   // ---------------- reference model ----------------
   localparam int S_IDLE = 0, S_RUN = 1, S_BURST = 2, S_HALT = 3;
   int          mSt;
   int          mPhase;   // cycles elapsed in the current divider period
   int          mRem;
   logic [31:0] mCnt;
   logic        mCk;
   logic        hist1, hist2, hist3;   // button samples 1, 2, 3 edges ago
   logic [42:0] exp_q[$];

   task automatic model_reset();
      mSt = S_IDLE; mPhase = 0; mRem = 0; mCnt = '0; mCk = 1'b0;
      hist1 = 1'b0; hist2 = 1'b0; hist3 = 1'b0;
      exp_q.delete();
   endtask

   // Advance the model across one rising edge using the inputs now applied.
   task automatic model_edge();
      int  period;
      int  nst;
      int  nrem;
      bit  active;
      bit  due;
      bit  pressed;
      bit  tick;
      period  = (DivSel == 2'd0) ? 1 : (DivSel == 2'd1) ? 1000 :
                (DivSel == 2'd2) ? 100000 : 50000000;
      active  = (mSt == S_RUN) || (mSt == S_BURST);
      due     = active && (mPhase >= period - 1);
      pressed = hist2 && !hist3;
      tick    = 1'b0;
      nst     = mSt;
      nrem    = mRem;
      if (HaltReq && mSt != S_HALT) begin
         nst = S_HALT; nrem = 0;
      end else if (mSt == S_IDLE) begin
         if (Mode == 2'b01) nst = S_RUN;
         else if (Mode == 2'b10 && pressed) tick = 1'b1;
         else if (Mode == 2'b11 && pressed && BurstLen != 0) begin
            nst = S_BURST; nrem = int'(BurstLen);
         end
      end else if (mSt == S_RUN) begin
         if (Mode != 2'b01) nst = S_IDLE;
         else if (due) tick = 1'b1;
      end else if (mSt == S_BURST) begin
         if (Mode == 2'b00) begin
            nst = S_IDLE; nrem = 0;
         end else if (due) begin
            tick = 1'b1;
            nrem = mRem - 1;
            if (nrem == 0) nst = S_IDLE;
         end
      end else begin
         if (Mode == 2'b00 && !HaltReq) nst = S_IDLE;
      end
      if (active && nst == mSt) mPhase = due ? 0 : mPhase + 1;
      else mPhase = 0;
      if (ClrCnt) mCnt = '0;
      else if (tick) mCnt = mCnt + 32'd1;
      hist3 = hist2; hist2 = hist1; hist1 = StepBtn;
      mCk  = tick;
      mSt  = nst;
      mRem = nrem;
      exp_q.push_back({mCk, (mSt == S_RUN || mSt == S_BURST), (mSt == S_HALT),
                       mRem[7:0], mCnt});
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int          ticks;
      int          firstAt;
      int          pulses;
      logic [31:0] cntBefore;
      logic [42:0] e;

      // Reset
      apply_reset();
      chk_all("reset", 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);

      // Free run at DivSel=1: ticks at 1000, 2000, ... after the entry edge
      Mode = 2'b01; DivSel = 2'd1;
      next_edge();
      chk("run_entry_busy", Busy, 1'b1);
      ticks = 0;
      for (int k = 1; k <= 5000; k++) begin
         next_edge();
         if (ClkEn) begin
            ticks++;
            chk($sformatf("run_tick%0d_cycle", ticks), k, ticks * 1000);
         end
      end
      chk("run_tick_total", ticks, 5);
      chk("run_cyclecnt", CycleCnt, 32'd5);
      chk("run_busy", Busy, 1'b1);
      Mode = 2'b00;
      next_edge();
      chk("run_exit_busy", Busy, 1'b0);
      ClrCnt = 1'b1;
      next_edge();
      ClrCnt = 1'b0;
      chk("clr_cnt", CycleCnt, 32'd0);

      // Single step with button held for 50 cycles
      Mode = 2'b10; StepBtn = 1'b1;
      firstAt = 0; pulses = 0;
      for (int k = 1; k <= 50; k++) begin
         next_edge();
         if (ClkEn) begin
            pulses++;
            if (firstAt == 0) firstAt = k;
         end
      end
      chk("step_first_edge", firstAt, 3);
      chk("step_pulses", pulses, 1);
      chk("step_cnt1", CycleCnt, 32'd1);
      StepBtn = 1'b0;
      repeat (5) next_edge();
      StepBtn = 1'b1;
      repeat (10) next_edge();
      StepBtn = 1'b0;
      chk("step_cnt2", CycleCnt, 32'd2);

      // Burst table (DivSel=0), zero-length burst, halt from idle
      DivSel = 2'd0;
      //     i  mode   btn  blen  halt clr | ck busy hlt rem cnt
      put( 0, 2'd0, 1'b0, 8'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      put( 1, 2'd3, 1'b0, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      put( 2, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      put( 3, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      put( 4, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'd3, 32'd0);
      put( 5, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd2, 32'd1);
      put( 6, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8'd1, 32'd2);
      put( 7, 2'd3, 1'b1, 8'd3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0, 32'd3);
      put( 8, 2'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put( 9, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(10, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(11, 2'd3, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(12, 2'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(13, 2'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(14, 2'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(15, 2'd3, 1'b1, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      put(16, 2'd0, 1'b0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 32'd3);
      put(17, 2'd1, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'd0, 32'd3);
      put(18, 2'd0, 1'b0, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0, 32'd3);
      for (int i = 0; i < 19; i++) begin
         Mode = vecs[i].mode; StepBtn = vecs[i].btn; BurstLen = vecs[i].blen;
         HaltReq = vecs[i].halt; ClrCnt = vecs[i].clr;
         next_edge();
         chk_all($sformatf("vec%0d", i), vecs[i].ck, vecs[i].busy, vecs[i].hlt,
                 vecs[i].rem, vecs[i].cnt);
      end
      ClrCnt = 1'b0; HaltReq = 1'b0;

      // Halt request on the cycle the divider is at its terminal count
      cntBefore = 32'd3;
      Mode = 2'b01; DivSel = 2'd1;
      next_edge();
      pulses = 0;
      for (int k = 1; k <= 999; k++) begin
         next_edge();
         if (ClkEn) pulses++;
      end
      chk("halt_pre_ticks", pulses, 0);
      HaltReq = 1'b1;
      next_edge();
      chk_all("halt_entry", 1'b0, 1'b0, 1'b1, 8'd0, cntBefore);
      Mode = 2'b01; HaltReq = 1'b0;
      repeat (5) next_edge();
      chk("halt_stay_run", Halted, 1'b1);
      chk("halt_stay_clken", ClkEn, 1'b0);
      Mode = 2'b00;
      next_edge();
      chk("halt_exit", Halted, 1'b0);
      chk("halt_exit_busy", Busy, 1'b0);

      // Counter wrap and clear-versus-tick priority
      Mode = 2'b10;
      force dut.CycleCnt = 32'hFFFF_FFFF;
      #1;
      release dut.CycleCnt;
      StepBtn = 1'b1;
      repeat (3) next_edge();
      chk("wrap_clken", ClkEn, 1'b1);
      chk("wrap_cnt", CycleCnt, 32'd0);
      StepBtn = 1'b0;
      repeat (4) next_edge();
      StepBtn = 1'b1;
      repeat (3) next_edge();
      chk("after_wrap_cnt", CycleCnt, 32'd1);
      StepBtn = 1'b0;
      repeat (4) next_edge();
      StepBtn = 1'b1;
      repeat (2) next_edge();
      ClrCnt = 1'b1;
      next_edge();
      chk("clr_vs_tick_clken", ClkEn, 1'b1);
      chk("clr_vs_tick_cnt", CycleCnt, 32'd0);
      ClrCnt = 1'b0; StepBtn = 1'b0; Mode = 2'b00;
      repeat (4) next_edge();

      // Switch from DivSel=2 to DivSel=1 with the counter past the new terminal
      Mode = 2'b01; DivSel = 2'd2;
      next_edge();
      pulses = 0;
      for (int k = 1; k <= 5000; k++) begin
         next_edge();
         if (ClkEn) pulses++;
      end
      chk("div2_no_ticks", pulses, 0);
      DivSel = 2'd1;
      next_edge();
      chk("divsel_shrink_tick", ClkEn, 1'b1);
      firstAt = 0;
      for (int k = 1; k <= 1000; k++) begin
         next_edge();
         if (ClkEn && firstAt == 0) firstAt = k;
      end
      chk("divsel_shrink_period", firstAt, 1000);
      Mode = 2'b00;
      next_edge();

      // Asynchronous reset in the middle of a burst
      Mode = 2'b11; DivSel = 2'd1; BurstLen = 8'd4; StepBtn = 1'b1;
      for (int k = 1; k <= 5000; k++) begin
         next_edge();
         if (k == 5) StepBtn = 1'b0;
         if (Remain == 8'd2) break;
      end
      chk("burst_reach_remain2", Remain, 8'd2);
      chk("burst_busy", Busy, 1'b1);
      StepBtn = 1'b0;
      #2;
      Rst = 1'b1;
      #1;
      chk_all("async_reset", 1'b0, 1'b0, 1'b0, 8'd0, 32'd0);
      next_edge();
      Rst = 1'b0;
      pulses = 0;
      for (int k = 1; k <= 20; k++) begin
         next_edge();
         if (ClkEn) pulses++;
      end
      chk("post_reset_no_tick", pulses, 0);
      chk("post_reset_busy", Busy, 1'b0);

      // Randomized stimulus against the reference model
      apply_reset();
      model_reset();
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 29) == 0) Mode = 2'($urandom_range(0, 3));
         if ($urandom_range(0, 49) == 0) DivSel = ($urandom_range(0, 9) == 0) ? 2'd2 : 2'($urandom_range(0, 1));
         if ($urandom_range(0, 5) == 0) StepBtn = ~StepBtn;
         BurstLen = 8'($urandom_range(0, 6));
         if (!HaltReq) HaltReq = ($urandom_range(0, 149) == 0);
         else HaltReq = ($urandom_range(0, 3) != 0);
         ClrCnt = ($urandom_range(0, 99) == 0);
         @(posedge Clk);
         model_edge();
         #1;
         e = exp_q.pop_front();
         chk($sformatf("rnd%0d.ClkEn", c),    ClkEn,    e[42]);
         chk($sformatf("rnd%0d.Busy", c),     Busy,     e[41]);
         chk($sformatf("rnd%0d.Halted", c),   Halted,   e[40]);
         chk($sformatf("rnd%0d.Remain", c),   Remain,   e[39:32]);
         chk($sformatf("rnd%0d.CycleCnt", c), CycleCnt, e[31:0]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
      $finish;
   end

endmodule
